// File: rtl/sc_collatz_engine_if.sv
// Handshake and datapath bundle for the Collatz engine.
// The controller (master) drives the commands and the engine (slave) returns the results.
interface sc_collatz_engine_if #(
  parameter int DATAWIDTH_BUS   = 8,
  parameter int DATAWIDTH_STEPS = 8
);
  logic                       SC_COLLATZ_start_In;
  logic                       SC_COLLATZ_abort_In;
  logic                       SC_COLLATZ_stepmode_In;
  logic                       SC_COLLATZ_step_In;
  logic [DATAWIDTH_BUS-1:0]   SC_COLLATZ_seed_InBUS;
  logic [DATAWIDTH_BUS-1:0]   SC_COLLATZ_value_OutBUS;
  logic [DATAWIDTH_STEPS-1:0] SC_COLLATZ_steps_OutBUS;
  logic [DATAWIDTH_BUS-1:0]   SC_COLLATZ_peak_OutBUS;
  logic                       SC_COLLATZ_busy_Out;
  logic                       SC_COLLATZ_done_Out;
  logic                       SC_COLLATZ_overflow_Out;
  logic                       SC_COLLATZ_timeout_Out;

  modport master (
    output SC_COLLATZ_start_In, SC_COLLATZ_abort_In, SC_COLLATZ_stepmode_In,
           SC_COLLATZ_step_In, SC_COLLATZ_seed_InBUS,
    input  SC_COLLATZ_value_OutBUS, SC_COLLATZ_steps_OutBUS, SC_COLLATZ_peak_OutBUS,
           SC_COLLATZ_busy_Out, SC_COLLATZ_done_Out, SC_COLLATZ_overflow_Out,
           SC_COLLATZ_timeout_Out
  );

  modport slave (
    input  SC_COLLATZ_start_In, SC_COLLATZ_abort_In, SC_COLLATZ_stepmode_In,
           SC_COLLATZ_step_In, SC_COLLATZ_seed_InBUS,
    output SC_COLLATZ_value_OutBUS, SC_COLLATZ_steps_OutBUS, SC_COLLATZ_peak_OutBUS,
           SC_COLLATZ_busy_Out, SC_COLLATZ_done_Out, SC_COLLATZ_overflow_Out,
           SC_COLLATZ_timeout_Out
  );
endinterface

// File: rtl/sc_collatz_engine.sv
// Collatz sequence engine: loads a seed and iterates n/2 or 3n+1 until n==1,
// tracking step count and peak, with overflow and step-limit error detection.
module sc_collatz_engine #(
  parameter int DATAWIDTH_BUS   = 8,
  parameter int DATAWIDTH_STEPS = 8
) (
  input  logic                SC_COLLATZ_CLOCK_50,
  input  logic                SC_COLLATZ_RESET_InHigh,
  sc_collatz_engine_if.slave  bus
);
  localparam int W = DATAWIDTH_BUS;
  localparam int S = DATAWIDTH_STEPS;

  typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} stateT;

  stateT          state, stateNext;
  logic [W-1:0]   value, valueNext;
  logic [W-1:0]   peak, peakNext;
  logic [S-1:0]   steps, stepsNext;
  logic           busy, busyNext;
  logic           done, doneNext;
  logic           overflow, overflowNext;
  logic           timeout, timeoutNext;

  logic           stepEn;
  logic           load;
  logic           stepGo;
  logic           oddN;
  logic [W+1:0]   tripled;
  logic [W+1:0]   candidate;
  logic           overflowHit;
  logic           timeoutHit;
  logic           stepOk;

  // 3n+1 is formed as n + 2n + 1 at W+2 bits so the carry-out reveals overflow.
  assign oddN        = value[0];
  assign tripled     = {2'b00, value} + {1'b0, value, 1'b0} + (W+2)'(1);
  assign candidate   = oddN ? tripled : {2'b00, (value >> 1)};
  assign overflowHit = oddN && (|tripled[W+1:W]);
  assign timeoutHit  = (steps == '1);

  assign stepEn = !bus.SC_COLLATZ_stepmode_In || bus.SC_COLLATZ_step_In;
  assign load   = (state != RUN) && !bus.SC_COLLATZ_abort_In && bus.SC_COLLATZ_start_In;
  assign stepGo = (state == RUN) && !bus.SC_COLLATZ_abort_In && stepEn;
  assign stepOk = stepGo && !timeoutHit && !overflowHit;

  always_ff @(posedge SC_COLLATZ_CLOCK_50 or posedge SC_COLLATZ_RESET_InHigh) begin
    if (SC_COLLATZ_RESET_InHigh) begin
      state    <= IDLE;
      value    <= '0;
      peak     <= '0;
      steps    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state    <= stateNext;
      value    <= valueNext;
      peak     <= peakNext;
      steps    <= stepsNext;
      busy     <= busyNext;
      done     <= doneNext;
      overflow <= overflowNext;
      timeout  <= timeoutNext;
    end
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      RUN: begin
        if (bus.SC_COLLATZ_abort_In) begin
          stateNext = IDLE;
        end else if (stepEn) begin
          if (timeoutHit || overflowHit) begin
            stateNext = ERR;
          end else if (candidate == (W+2)'(1)) begin
            stateNext = DONE;
          end
        end
      end
      default: begin
        if (bus.SC_COLLATZ_abort_In) begin
          stateNext = IDLE;
        end else if (bus.SC_COLLATZ_start_In) begin
          if (bus.SC_COLLATZ_seed_InBUS == '0) begin
            stateNext = ERR;
          end else if (bus.SC_COLLATZ_seed_InBUS == W'(1)) begin
            stateNext = DONE;
          end else begin
            stateNext = RUN;
          end
        end
      end
    endcase
  end

  // Flags are computed one cycle ahead so every output comes straight from a flop.
  always_comb begin
    valueNext    = value;
    peakNext     = peak;
    stepsNext    = steps;
    busyNext     = (stateNext == RUN);
    doneNext     = (stateNext == DONE);
    overflowNext = overflow;
    timeoutNext  = timeout;

    if (bus.SC_COLLATZ_abort_In || load) begin
      overflowNext = 1'b0;
      timeoutNext  = 1'b0;
    end else if (stepGo) begin
      timeoutNext  = timeoutHit;
      overflowNext = !timeoutHit && overflowHit;
    end

    if (load) begin
      valueNext = bus.SC_COLLATZ_seed_InBUS;
      peakNext  = bus.SC_COLLATZ_seed_InBUS;
      stepsNext = '0;
    end else if (stepOk) begin
      valueNext = candidate[W-1:0];
      stepsNext = steps + S'(1);
      if (candidate[W-1:0] > peak) begin
        peakNext = candidate[W-1:0];
      end
    end
  end

  assign bus.SC_COLLATZ_value_OutBUS = value;
  assign bus.SC_COLLATZ_peak_OutBUS  = peak;
  assign bus.SC_COLLATZ_steps_OutBUS = steps;
  assign bus.SC_COLLATZ_busy_Out     = busy;
  assign bus.SC_COLLATZ_done_Out     = done;
  assign bus.SC_COLLATZ_overflow_Out = overflow;
  assign bus.SC_COLLATZ_timeout_Out  = timeout;
endmodule

// File: tb/tb_sc_collatz_engine.sv
// Bench for sc_collatz_engine: two instances (S=8 and S=4) share one stimulus stream
// and are compared edge by edge against a plain-arithmetic Collatz model.
module tb_sc_collatz_engine;
  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic       stepmode;
  logic       step;
  logic [7:0] seedIn;

  int nAssert;
  int nFail;

  // Model results per instance: kind 0=done 1=overflow 2=timeout 3=invalid seed.
  int mKind [2];
  int mSteps[2];
  int mTerm [2];
  int mTraj [2][0:300];

  sc_collatz_engine_if #(.DATAWIDTH_BUS(8), .DATAWIDTH_STEPS(8)) ifA ();
  sc_collatz_engine_if #(.DATAWIDTH_BUS(8), .DATAWIDTH_STEPS(4)) ifB ();

  assign ifA.SC_COLLATZ_start_In    = start;
  assign ifA.SC_COLLATZ_abort_In    = abort;
  assign ifA.SC_COLLATZ_stepmode_In = stepmode;
  assign ifA.SC_COLLATZ_step_In     = step;
  assign ifA.SC_COLLATZ_seed_InBUS  = seedIn;
  assign ifB.SC_COLLATZ_start_In    = start;
  assign ifB.SC_COLLATZ_abort_In    = abort;
  assign ifB.SC_COLLATZ_stepmode_In = stepmode;
  assign ifB.SC_COLLATZ_step_In     = step;
  assign ifB.SC_COLLATZ_seed_InBUS  = seedIn;

  sc_collatz_engine #(.DATAWIDTH_BUS(8), .DATAWIDTH_STEPS(8)) dutA (
    .SC_COLLATZ_CLOCK_50     (clk),
    .SC_COLLATZ_RESET_InHigh (rst),
    .bus                     (ifA)
  );

  sc_collatz_engine #(.DATAWIDTH_BUS(8), .DATAWIDTH_STEPS(4)) dutB (
    .SC_COLLATZ_CLOCK_50     (clk),
    .SC_COLLATZ_RESET_InHigh (rst),
    .bus                     (ifB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic getObs(input int idx, output logic [31:0] v, output logic [31:0] st,
                        output logic [31:0] pk, output logic [31:0] bz, output logic [31:0] dn,
                        output logic [31:0] ov, output logic [31:0] tm);
    if (idx == 0) begin
      v  = 32'(ifA.SC_COLLATZ_value_OutBUS);
      st = 32'(ifA.SC_COLLATZ_steps_OutBUS);
      pk = 32'(ifA.SC_COLLATZ_peak_OutBUS);
      bz = 32'(ifA.SC_COLLATZ_busy_Out);
      dn = 32'(ifA.SC_COLLATZ_done_Out);
      ov = 32'(ifA.SC_COLLATZ_overflow_Out);
      tm = 32'(ifA.SC_COLLATZ_timeout_Out);
    end else begin
      v  = 32'(ifB.SC_COLLATZ_value_OutBUS);
      st = 32'(ifB.SC_COLLATZ_steps_OutBUS);
      pk = 32'(ifB.SC_COLLATZ_peak_OutBUS);
      bz = 32'(ifB.SC_COLLATZ_busy_Out);
      dn = 32'(ifB.SC_COLLATZ_done_Out);
      ov = 32'(ifB.SC_COLLATZ_overflow_Out);
      tm = 32'(ifB.SC_COLLATZ_timeout_Out);
    end
  endtask

  task automatic checkAll(input string tag, input int idx, input int v, input int st,
                          input int pk, input int bz, input int dn, input int ov, input int tm);
    logic [31:0] oV, oSt, oPk, oBz, oDn, oOv, oTm;
    getObs(idx, oV, oSt, oPk, oBz, oDn, oOv, oTm);
    chk($sformatf("%s_i%0d_value", tag, idx), oV, v);
    chk($sformatf("%s_i%0d_steps", tag, idx), oSt, st);
    chk($sformatf("%s_i%0d_peak", tag, idx), oPk, pk);
    chk($sformatf("%s_i%0d_busy", tag, idx), oBz, bz);
    chk($sformatf("%s_i%0d_done", tag, idx), oDn, dn);
    chk($sformatf("%s_i%0d_ovf", tag, idx), oOv, ov);
    chk($sformatf("%s_i%0d_tmo", tag, idx), oTm, tm);
  endtask

  // Plain Collatz iteration with an 8-bit value range and a 2^sb-1 step ceiling.
  task automatic model(input int idx, input int seed, input int sb);
    int n, st, nx;
    bit fin;
    n = seed; st = 0; fin = 0;
    mTraj[idx][0] = seed;
    if (seed == 0) begin
      mKind[idx] = 3; mTerm[idx] = 0; fin = 1;
    end else if (seed == 1) begin
      mKind[idx] = 0; mTerm[idx] = 0; fin = 1;
    end
    for (int g = 0; g < 1000 && !fin; g++) begin
      if (st == (1 << sb) - 1) begin
        mKind[idx] = 2; mTerm[idx] = st + 1; fin = 1;
      end else begin
        nx = (n % 2 == 1) ? 3 * n + 1 : n / 2;
        if (nx > 255) begin
          mKind[idx] = 1; mTerm[idx] = st + 1; fin = 1;
        end else begin
          n = nx; st++;
          mTraj[idx][st] = n;
          if (n == 1) begin
            mKind[idx] = 0; mTerm[idx] = st; fin = 1;
          end
        end
      end
    end
    mSteps[idx] = st;
  endtask

  // Expected outputs i edges after the load edge, from the model trajectory.
  task automatic checkEdge(input int idx, input int i);
    int k, pk, term;
    bit after;
    k = (i < mSteps[idx]) ? i : mSteps[idx];
    pk = 0;
    for (int j = 0; j <= k; j++) if (mTraj[idx][j] > pk) pk = mTraj[idx][j];
    term  = mTerm[idx];
    after = (i >= term);
    checkAll($sformatf("seed%0d_e%0d", mTraj[idx][0], i), idx, mTraj[idx][k], k, pk,
             int'(!after), int'(after && mKind[idx] == 0),
             int'(after && mKind[idx] == 1), int'(after && mKind[idx] == 2));
  endtask

  task automatic runSeed(input int seed, input bit extraStart);
    int last;
    model(0, seed, 8);
    model(1, seed, 4);
    @(negedge clk);
    seedIn = 8'(seed);
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkEdge(0, 0);
    checkEdge(1, 0);
    last = ((mTerm[0] > mTerm[1]) ? mTerm[0] : mTerm[1]) + 2;
    for (int i = 1; i <= last; i++) begin
      start  = extraStart && (i == 2);
      seedIn = start ? 8'd5 : 8'(seed);
      @(negedge clk);
      checkEdge(0, i);
      checkEdge(1, i);
    end
    start = 1'b0;
  endtask

  initial begin
    nAssert  = 0;
    nFail    = 0;
    rst      = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    stepmode = 1'b0;
    step     = 1'b0;
    seedIn   = '0;

    #12;
    checkAll("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    checkAll("reset", 1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    runSeed(6, 1'b0);
    checkAll("s6_final", 0, 1, 8, 16, 0, 1, 0, 0);

    // A second start arrives mid-run and must be ignored.
    runSeed(27, 1'b1);
    checkAll("s27_final", 0, 107, 11, 214, 0, 0, 1, 0);

    runSeed(7, 1'b0);
    checkAll("s7_final_s4", 1, 2, 15, 52, 0, 0, 0, 1);
    checkAll("s7_final_s8", 0, 1, 16, 52, 0, 1, 0, 0);

    runSeed(1, 1'b0);
    checkAll("s1_final", 0, 1, 0, 1, 0, 1, 0, 0);
    runSeed(0, 1'b0);
    checkAll("s0_final", 0, 0, 0, 0, 0, 0, 0, 0);
    checkAll("s0_final", 1, 0, 0, 0, 0, 0, 0, 0);

    // Single-step mode with idle gaps between step pulses.
    stepmode = 1'b1;
    seedIn   = 8'd6;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkAll("sm_load", 0, 6, 0, 6, 1, 0, 0, 0);
    for (int p = 0; p < 3; p++) begin
      int expV [3] = '{3, 10, 5};
      int expP [3] = '{6, 10, 10};
      int prevV, prevP;
      prevV = (p == 0) ? 6 : expV[p-1];
      prevP = (p == 0) ? 6 : expP[p-1];
      repeat (2) begin
        @(negedge clk);
        checkAll($sformatf("sm_gap%0d", p), 0, prevV, p, prevP, 1, 0, 0, 0);
      end
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      checkAll($sformatf("sm_step%0d", p), 0, expV[p], p + 1, expP[p], 1, 0, 0, 0);
    end
    abort = 1'b1;
    @(negedge clk);
    abort    = 1'b0;
    stepmode = 1'b0;
    checkAll("sm_abort", 0, 5, 3, 10, 0, 0, 0, 0);

    // Abort sampled on the 4th edge after load: value of edge 3 is retained.
    seedIn = 8'd7;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checkAll("ab_pre", 0, 34, 3, 34, 1, 0, 0, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkAll("ab_idle", 0, 34, 3, 34, 0, 0, 0, 0);
    checkAll("ab_idle", 1, 34, 3, 34, 0, 0, 0, 0);
    start  = 1'b1;
    abort  = 1'b1;
    seedIn = 8'd9;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    checkAll("ab_both", 0, 34, 3, 34, 0, 0, 0, 0);
    @(negedge clk);
    checkAll("ab_both2", 1, 34, 3, 34, 0, 0, 0, 0);

    // Asynchronous reset mid-run, checked before the next rising edge.
    seedIn = 8'd27;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkAll("arst", 0, 0, 0, 0, 0, 0, 0, 0);
    checkAll("arst", 1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkAll("arst_after", 0, 0, 0, 0, 0, 0, 0, 0);

    for (int r = 0; r < 20; r++) begin
      runSeed(int'($urandom_range(0, 255)), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end
endmodule
